// File: rtl/matrix_mult_sequencer.sv
// matrix_mult_sequencer: runs one 2x2 unsigned matrix multiply through a single shared
// multiplier, packs the eight products for the external adder and returns the registered sums.
module matrix_mult_sequencer #(
  parameter int ELEM_W  = 3,
  parameter int PROD_W  = 6,
  parameter int MUL_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*ELEM_W-1:0]   mat_a,
  input  logic [4*ELEM_W-1:0]   mat_b,
  output logic [ELEM_W-1:0]     mul_a,
  output logic [ELEM_W-1:0]     mul_b,
  input  logic [PROD_W-1:0]     mul_p,
  output logic [8*PROD_W-1:0]   products_out,
  input  logic [4*PROD_W-1:0]   sum_in,
  output logic [4*PROD_W-1:0]   result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  localparam int CW = 4;
  localparam logic [CW-1:0] LAST = CW'(7 + MUL_LAT);
  localparam logic [CW-1:0] OFS  = CW'(8 - MUL_LAT);
  typedef enum logic [1:0] {IDLE, MUL, SUM, DONE} state_e;
  state_e                state_q, state_d;
  logic [4*ELEM_W-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [8*PROD_W-1:0]   prod_q, prod_d;
  logic [4*PROD_W-1:0]   res_q, res_d;
  logic                  valid_q, valid_d;
  logic [CW-1:0]         off;
  logic [1:0]            a_idx, b_idx;
  logic                  issue, capture;
  // cnt_q counts MUL cycles; off = cnt_q - MUL_LAT + 8, so off[3] marks a capture and off[2:0] its slot
  assign off     = cnt_q + OFS;
  assign issue   = state_q == MUL && !cnt_q[3];
  assign capture = state_q == MUL && off[3];
  assign a_idx   = {cnt_q[2], cnt_q[0]};
  assign b_idx   = {cnt_q[0], cnt_q[1]};
  assign mul_a   = issue ? a_q[a_idx*ELEM_W +: ELEM_W] : '0;
  assign mul_b   = issue ? b_q[b_idx*ELEM_W +: ELEM_W] : '0;
  assign in_ready     = state_q == IDLE;
  assign busy         = state_q != IDLE;
  assign out_valid    = valid_q;
  assign result       = res_q;
  assign products_out = prod_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    res_d   = res_q;
    valid_d = valid_q;
    if (capture) prod_d[off[2:0]*PROD_W +: PROD_W] = mul_p;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = mat_a;
        b_d     = mat_b;
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == LAST ? SUM : MUL;
      end
      SUM: begin
        res_d   = sum_in;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// tb_matrix_mult_sequencer: two lanes (MUL_LAT 0 and 2), each with its own multiplier/adder
// models, directed stimulus and a scoreboard monitor popping expected results on handshake.
module tb_matrix_mult_sequencer;
  logic clk = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;

  task automatic chk(input int ln, input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %0h expected %0h", ln, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = 2 * g;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [11:0] mat_a, mat_b;
    logic [2:0]  mul_a, mul_b;
    logic [5:0]  mul_p, p0, p1, p2;
    logic [47:0] products_out;
    logic [23:0] sum_in, result;
    logic [23:0] exp_q[$];
    bit          done = 1'b0;
    int          asel[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int          bsel[8] = '{0, 2, 1, 3, 0, 2, 1, 3};

    matrix_mult_sequencer #(.ELEM_W(3), .PROD_W(6), .MUL_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mat_a(mat_a), .mat_b(mat_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .products_out(products_out), .sum_in(sum_in), .result(result),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    assign p0 = {3'b0, mul_a} * {3'b0, mul_b};
    always @(posedge clk) begin
      p1 <= p0;
      p2 <= p1;
    end
    assign mul_p = LAT == 0 ? p0 : p2;
    for (genvar j = 0; j < 4; j++) begin : add
      assign sum_in[j*6 +: 6] = products_out[2*j*6 +: 6] + products_out[(2*j+1)*6 +: 6];
    end

    initial forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(g, "result_unexpected", {24'd0, result}, 48'hDEAD);
        else chk(g, "result", {24'd0, result}, {24'd0, exp_q.pop_front()});
      end
    end

    task automatic wait_idle();
      int c;
      @(negedge clk);
      for (c = 0; c < 40 && !in_ready; c++) @(negedge clk);
      chk(g, "ready_wait", {47'd0, in_ready}, 48'd1);
    endtask

    task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic [23:0] e, input int hold);
      int c;
      int bad;
      wait_idle();
      @(posedge clk); #1;
      in_valid = 1'b1; mat_a = a; mat_b = b; out_ready = hold == 0;
      @(negedge clk);
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0; mat_a = ~a; mat_b = b ^ 12'h5A5;
      for (c = 0; c < 60; c++) begin
        @(negedge clk);
        if (c < 8) begin
          chk(g, $sformatf("mul_a k%0d", c), {45'd0, mul_a}, {45'd0, a[asel[c]*3 +: 3]});
          chk(g, $sformatf("mul_b k%0d", c), {45'd0, mul_b}, {45'd0, b[bsel[c]*3 +: 3]});
        end else if (c == 8) chk(g, "mul_idle", {42'd0, mul_a, mul_b}, 48'd0);
        if (out_valid) break;
      end
      chk(g, "latency", 48'(c), 48'(9 + LAT));
      if (hold > 0) begin
        bad = 0;
        repeat (hold) begin
          @(negedge clk);
          if ({out_valid, busy, in_ready} !== 3'b110 || result !== e) bad++;
        end
        chk(g, "backpressure_hold", 48'(bad), 48'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk(g, "idle_after_handshake", {45'd0, out_valid, busy, in_ready}, 48'd1);
        out_ready = 1'b1;
      end
    endtask

    task automatic reset_mid();
      int bad;
      wait_idle();
      @(posedge clk); #1;
      in_valid = 1'b1; mat_a = 12'hFFF; mat_b = 12'hFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk(g, "pre_reset_issue4", {42'd0, mul_a, mul_b}, {42'd0, 3'd7, 3'd7});
      rst_n = 1'b0;
      #1;
      chk(g, "abort_state", {46'd0, busy, in_ready}, 48'd1);
      chk(g, "abort_products", products_out, 48'd0);
      chk(g, "abort_mul", {41'd0, out_valid, mul_a, mul_b}, 48'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (30) begin
        @(negedge clk);
        if (out_valid || busy || products_out !== 48'd0) bad++;
      end
      chk(g, "quiet_after_reset", 48'(bad), 48'd0);
    endtask

    task automatic b2b(input logic [11:0] a1, input logic [11:0] b1, input logic [23:0] e1,
                       input logic [11:0] a2, input logic [11:0] b2, input logic [23:0] e2);
      int c;
      int v;
      int acc;
      wait_idle();
      @(posedge clk); #1;
      in_valid = 1'b1; mat_a = a1; mat_b = b1; out_ready = 1'b1;
      @(negedge clk);
      exp_q.push_back(e1);
      @(posedge clk); #1;
      mat_a = a2; mat_b = b2;
      v = -1;
      acc = -1;
      for (c = 0; c < 60; c++) begin
        @(negedge clk);
        if (out_valid && v < 0) v = c;
        if (in_ready && v >= 0) begin
          acc = c;
          exp_q.push_back(e2);
          break;
        end
      end
      chk(g, "b2b_first_latency", 48'(v), 48'(9 + LAT));
      chk(g, "b2b_accept_gap", 48'(acc + 1 - v), 48'd2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (c = 0; c < 60; c++) begin
        @(negedge clk);
        if (out_valid) break;
      end
      chk(g, "b2b_second_latency", 48'(c), 48'(9 + LAT));
    endtask

    initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mat_a = '0; mat_b = '0;
      #3;
      chk(g, "reset_flags", {45'd0, in_ready, busy, out_valid}, 48'd4);
      chk(g, "reset_products", products_out, 48'd0);
      chk(g, "reset_result_mul", {18'd0, result, mul_a, mul_b}, 48'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(12'h201, 12'h8D1, 24'h103081, 0);
      run_op(12'hFFF, 12'hFFF, 24'h8A28A2, 20);
      reset_mid();
      run_op(12'h05A, 12'h8D1, 24'h08140B, 0);
      b2b(12'h05A, 12'h8D1, 24'h08140B, 12'hFFF, 12'hFFF, 24'h8A28A2);
      repeat (4) @(negedge clk);
      chk(g, "scoreboard_drained", 48'(exp_q.size()), 48'd0);
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (lane[0].done && lane[1].done);
      #100000;
    join_any
    if (!(lane[0].done && lane[1].done)) begin
      checks++;
      errors++;
      $display("FAIL timeout: lanes done=%0b%0b required 11", lane[1].done, lane[0].done);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
